// File: rtl/fat32_stream_writer_if.sv
// fat32_stream_writer_if
//   Bundles every non-clock signal of fat32_stream_writer.
//   Groups:
//     BPB capture : bpb_en, bpb_addr[8:0], bpb_byte[7:0], bpb_done
//     payload in  : in_valid, in_data[7:0], in_ready, flush
//     sector out  : wr_start, wr_sector[31:0], wr_busy, wr_req,
//                   wr_byte[7:0], wr_done
//     status      : file_length[31:0], ready, err
//   Modports: slave  = the writer itself
//             master = whatever drives the writer (sector reader, source, sink)
interface fat32_stream_writer_if;
    logic        bpb_en;
    logic [8:0]  bpb_addr;
    logic [7:0]  bpb_byte;
    logic        bpb_done;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic        wr_start;
    logic [31:0] wr_sector;
    logic        wr_busy;
    logic        wr_req;
    logic [7:0]  wr_byte;
    logic        wr_done;
    logic [31:0] file_length;
    logic        ready;
    logic        err;

    modport slave (
        input  bpb_en, bpb_addr, bpb_byte, bpb_done,
        input  in_valid, in_data, flush,
        input  wr_busy, wr_req, wr_done,
        output in_ready, wr_start, wr_sector, wr_byte,
        output file_length, ready, err
    );

    modport master (
        output bpb_en, bpb_addr, bpb_byte, bpb_done,
        output in_valid, in_data, flush,
        output wr_busy, wr_req, wr_done,
        input  in_ready, wr_start, wr_sector, wr_byte,
        input  file_length, ready, err
    );
endinterface

// File: rtl/fat32_stream_writer.sv
// fat32_stream_writer
//   Streams payload bytes into a FAT32 file whose clusters are contiguous from
//   FILE_START_CLUSTER. The BPB of sector 0 is captured while it is read, the
//   absolute first data sector is derived from it, and payload is gathered into
//   BUF_SECTORS 512-byte slots that are handed one at a time to a downstream
//   sector writer.
//   Ports:
//     clk  - single clock
//     rstn - asynchronous active-low reset
//     bus  - fat32_stream_writer_if.slave (BPB capture, payload in with
//            valid/ready, sector-write request/fetch/done, status outputs)
//   Optional feature: define FLUSH_PAD_EN to let a flush pulse pad the partial
//   slot with PAD_BYTE and commit it; file_length then grows only by the real
//   byte count. Without it, flush is ignored and only full sectors are written.
module fat32_stream_writer #(
    parameter int         BUF_SECTORS        = 2,
    parameter int         FILE_START_CLUSTER = 3,
    parameter int         MAX_SECTORS        = 4096,
    parameter logic [7:0] PAD_BYTE           = 8'h00
) (
    input logic clk,
    input logic rstn,
    fat32_stream_writer_if.slave bus
);
    localparam int SLOT_W = $clog2(BUF_SECTORS);

    typedef enum logic [2:0] {WAIT_BPB, CALC, RUN, STOP, ERR} stateT;

    stateT state, nextState;

    logic [15:0] bytesPerSec, rsvdSecs;
    logic [7:0]  secPerClus, numFats;
    logic [31:0] fatLen, startSector, calcStart;
    logic        bpbValid;

    logic [7:0]            buffer [BUF_SECTORS*512];
    logic [BUF_SECTORS-1:0] slotFull;
    logic [SLOT_W-1:0]     wrSlot, rdSlot;
    logic [SLOT_W:0]       fullCount;
    logic [8:0]            fillPtr, xferPtr;
    logic [31:0]           sectorIndex;
    logic                  xferActive;
    logic [9:0]            doneBytes;

    logic accept, wrEn, commit, startXfer, doneXfer, limitHit;
    logic padding, padStart;

    assign bpbValid  = (bytesPerSec == 16'd512) && (numFats != 8'd0) && (secPerClus != 8'd0);
    assign calcStart = 32'(rsvdSecs) + 32'(numFats) * fatLen
                     + 32'(FILE_START_CLUSTER - 2) * 32'(secPerClus);

    // Committed-but-unwritten slots count toward the limit, so sectorIndex +
    // fullCount is the number of sectors ever committed.
    assign limitHit  = (sectorIndex + 32'(fullCount)) == 32'(MAX_SECTORS);

    // Slots fill in ring order, so the write slot being full means all are.
    assign bus.in_ready = (state == RUN) && !slotFull[wrSlot] && !limitHit
                        && !padding && !padStart;

    assign accept    = bus.in_valid && bus.in_ready;
    assign wrEn      = accept || padding;
    assign commit    = wrEn && (fillPtr == 9'd511);
    assign startXfer = !xferActive && slotFull[rdSlot] && !bus.wr_busy;
    assign doneXfer  = xferActive && bus.wr_done;

`ifdef FLUSH_PAD_EN
    logic [9:0] padLen;
    logic [9:0] slotLen [BUF_SECTORS];

    assign padStart  = (state == RUN) && bus.flush && (fillPtr != 9'd0) && !padding;
    assign doneBytes = slotLen[rdSlot];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            padding <= 1'b0;
            padLen  <= 10'd0;
        end else if (padStart) begin
            padding <= 1'b1;
            padLen  <= {1'b0, fillPtr};
        end else if (commit) begin
            padding <= 1'b0;
        end
    end

    // Real byte count of each slot, written before the slot can be fetched.
    always_ff @(posedge clk) begin
        if (commit) slotLen[wrSlot] <= padding ? padLen : 10'd512;
    end
`else
    assign padding   = 1'b0;
    assign padStart  = 1'b0;
    assign doneBytes = 10'd512;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= WAIT_BPB;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            WAIT_BPB: if (bus.bpb_done) nextState = CALC;
            CALC:     nextState = bpbValid ? RUN : ERR;
            RUN:      if (limitHit) nextState = STOP;
            default:  nextState = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wrEn) buffer[{wrSlot, fillPtr}] <= padding ? PAD_BYTE : bus.in_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bytesPerSec     <= '0;
            rsvdSecs        <= '0;
            secPerClus      <= '0;
            numFats         <= '0;
            fatLen          <= '0;
            startSector     <= '0;
            slotFull        <= '0;
            wrSlot          <= '0;
            rdSlot          <= '0;
            fullCount       <= '0;
            fillPtr         <= '0;
            xferPtr         <= '0;
            sectorIndex     <= '0;
            xferActive      <= 1'b0;
            bus.ready       <= 1'b0;
            bus.err         <= 1'b0;
            bus.wr_start    <= 1'b0;
            bus.wr_sector   <= '0;
            bus.wr_byte     <= '0;
            bus.file_length <= '0;
        end else begin
            if (bus.bpb_en) begin
                case (bus.bpb_addr)
                    9'h00B: bytesPerSec[7:0]  <= bus.bpb_byte;
                    9'h00C: bytesPerSec[15:8] <= bus.bpb_byte;
                    9'h00D: secPerClus        <= bus.bpb_byte;
                    9'h00E: rsvdSecs[7:0]     <= bus.bpb_byte;
                    9'h00F: rsvdSecs[15:8]    <= bus.bpb_byte;
                    9'h010: numFats           <= bus.bpb_byte;
                    9'h024: fatLen[7:0]       <= bus.bpb_byte;
                    9'h025: fatLen[15:8]      <= bus.bpb_byte;
                    9'h026: fatLen[23:16]     <= bus.bpb_byte;
                    9'h027: fatLen[31:24]     <= bus.bpb_byte;
                    default: ;
                endcase
            end

            if (state == CALC) startSector <= calcStart;
            bus.ready <= (nextState == RUN) || (nextState == STOP);
            bus.err   <= (nextState == ERR);

            if (wrEn) fillPtr <= fillPtr + 9'd1;
            if (commit) begin
                slotFull[wrSlot] <= 1'b1;
                wrSlot           <= wrSlot + 1'b1;
            end

            // Commit and completion touch different slots, so both may land
            // in one cycle; the occupancy count nets them out.
            case ({commit, doneXfer})
                2'b10:   fullCount <= fullCount + 1'b1;
                2'b01:   fullCount <= fullCount - 1'b1;
                default: fullCount <= fullCount;
            endcase

            bus.wr_start <= startXfer;
            if (startXfer) begin
                bus.wr_sector <= startSector + sectorIndex;
                xferActive    <= 1'b1;
                xferPtr       <= '0;
            end

            if (xferActive && bus.wr_req) begin
                bus.wr_byte <= buffer[{rdSlot, xferPtr}];
                xferPtr     <= xferPtr + 9'd1;
            end

            // wr_done outside a transfer (e.g. one begun before a reset) is dropped.
            if (doneXfer) begin
                xferActive       <= 1'b0;
                slotFull[rdSlot] <= 1'b0;
                rdSlot           <= rdSlot + 1'b1;
                sectorIndex      <= sectorIndex + 32'd1;
                bus.file_length  <= bus.file_length + 32'(doneBytes);
            end
        end
    end
endmodule

// File: tb/tb_fat32_stream_writer.sv
// tb_fat32_stream_writer
//   Directed bench for fat32_stream_writer (BUF_SECTORS=2, MAX_SECTORS=3,
//   PAD_BYTE=8'hA5). A background sink answers every wr_start by fetching 512
//   bytes with gapped wr_req strobes and then pulsing wr_done; a monitor logs
//   every wr_start pulse and its wr_sector. Build with FLUSH_PAD_EN defined to
//   exercise the padded flush path instead of the ignored-flush path.
module tb_fat32_stream_writer;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fat32_stream_writer_if bus();

    fat32_stream_writer #(
        .BUF_SECTORS(2),
        .FILE_START_CLUSTER(3),
        .MAX_SECTORS(3),
        .PAD_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus.slave)
    );

    int nChecks = 0;
    int nFails  = 0;
    int pulseCount = 0;
    logic [31:0] sectorLog [$];
    logic [7:0]  capt [$];
    bit respBusy = 1'b0;

    initial begin : monitor
        forever begin
            @(posedge clk); #1;
            if (bus.wr_start === 1'b1) begin
                pulseCount++;
                sectorLog.push_back(bus.wr_sector);
            end
        end
    end

    initial begin : sink
        bus.wr_req  = 1'b0;
        bus.wr_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.wr_start === 1'b1) begin
                respBusy = 1'b1;
                for (int i = 0; i < 512; i++) begin
                    bus.wr_req = 1'b1;
                    @(posedge clk); #1;
                    bus.wr_req = 1'b0;
                    capt.push_back(bus.wr_byte);
                    @(posedge clk); #1;
                end
                bus.wr_done = 1'b1;
                @(posedge clk); #1;
                bus.wr_done = 1'b0;
                respBusy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic applyReset();
        rstn = 1'b0;
        bus.bpb_en = 1'b0; bus.bpb_addr = '0; bus.bpb_byte = '0; bus.bpb_done = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0; bus.wr_busy = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic writeBpb(input logic [8:0] addr, input logic [7:0] data);
        bus.bpb_en = 1'b1; bus.bpb_addr = addr; bus.bpb_byte = data;
        tick(1);
        bus.bpb_en = 1'b0;
    endtask

    // Returns just after the edge that samples bpb_done (the FSM is in CALC).
    task automatic loadBpb(input logic [15:0] bps, input logic [7:0] spc,
                           input logic [15:0] rsvd, input logic [7:0] nfat,
                           input logic [31:0] fatlen);
        writeBpb(9'h000, 8'hEB);
        writeBpb(9'h00B, bps[7:0]);
        writeBpb(9'h00C, bps[15:8]);
        writeBpb(9'h00D, spc);
        writeBpb(9'h00E, rsvd[7:0]);
        writeBpb(9'h00F, rsvd[15:8]);
        writeBpb(9'h010, nfat);
        writeBpb(9'h011, 8'hFF);
        writeBpb(9'h024, fatlen[7:0]);
        writeBpb(9'h025, fatlen[15:8]);
        writeBpb(9'h026, fatlen[23:16]);
        writeBpb(9'h027, fatlen[31:24]);
        bus.bpb_done = 1'b1;
        tick(1);
        bus.bpb_done = 1'b0;
    endtask

    // Offers bytes (base+k) mod 256 until n are taken or the cycle budget runs out.
    task automatic sendBytes(input int n, input int base, input int budget, output int accepted);
        int cycles;
        logic rdy;
        accepted = 0;
        cycles = 0;
        while (accepted < n && cycles < budget) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(base + accepted);
            rdy = bus.in_ready;
            tick(1);
            cycles++;
            if (rdy) accepted++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic waitLen(input logic [31:0] len, input int budget);
        int cycles = 0;
        while (bus.file_length !== len && cycles < budget) begin
            tick(1);
            cycles++;
        end
    endtask

    task automatic waitSinkIdle(input int budget);
        int cycles = 0;
        while (respBusy && cycles < budget) begin
            tick(1);
            cycles++;
        end
    endtask

    // Mismatches of capt[from +: n] against k mod 256 for k < padFrom, 8'hA5 after.
    function automatic int countMism(input int from, input int n, input int padFrom);
        int bad = 0;
        logic [7:0] exp;
        for (int k = 0; k < n; k++) begin
            exp = (k < padFrom) ? 8'(k) : 8'hA5;
            if (from + k >= capt.size()) bad++;
            else if (capt[from + k] !== exp) bad++;
        end
        return bad;
    endfunction

    function automatic logic [31:0] sectorAt(input int idx);
        if (idx < sectorLog.size()) return sectorLog[idx];
        return 32'hDEAD_BEEF;
    endfunction

    initial begin : stimulus
        int acc, p0, s0, c0;

        // Reset values while rstn is held low
        bus.bpb_en = 1'b0; bus.bpb_addr = '0; bus.bpb_byte = '0; bus.bpb_done = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0; bus.wr_busy = 1'b0;
        tick(2);
        check("reset in_ready", 32'(bus.in_ready), 0);
        check("reset wr_start", 32'(bus.wr_start), 0);
        check("reset ready", 32'(bus.ready), 0);
        check("reset err", 32'(bus.err), 0);
        check("reset wr_sector", bus.wr_sector, 0);
        check("reset wr_byte", 32'(bus.wr_byte), 0);
        check("reset file_length", bus.file_length, 0);
        rstn = 1'b1;
        tick(1);

        // Valid BPB: start = 32 + 2*1000 + 1*8 = 2040; two full sectors
        loadBpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd1000);
        check("ready during CALC", 32'(bus.ready), 0);
        tick(1);
        check("ready two cycles after bpb_done", 32'(bus.ready), 1);
        check("err on valid BPB", 32'(bus.err), 0);
        check("in_ready in RUN", 32'(bus.in_ready), 1);
        p0 = pulseCount; s0 = sectorLog.size(); c0 = capt.size();
        sendBytes(1024, 0, 3000, acc);
        check("stream accepted", acc, 1024);
        waitLen(32'd1024, 4000);
        check("file_length after two sectors", bus.file_length, 1024);
        check("wr_start pulses two sectors", pulseCount - p0, 2);
        check("first wr_sector", sectorAt(s0), 2040);
        check("second wr_sector", sectorAt(s0 + 1), 2041);
        check("fetched byte count", capt.size() - c0, 1024);
        check("fetched byte mismatches", countMism(c0, 1024, 1024), 0);

        // Downstream busy: both slots fill, input stalls, then resumes
        applyReset();
        bus.wr_busy = 1'b1;
        loadBpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd1000);
        tick(1);
        p0 = pulseCount; c0 = capt.size();
        sendBytes(1100, 0, 1200, acc);
        check("accepted while busy", acc, 1024);
        check("in_ready with both slots full", 32'(bus.in_ready), 0);
        check("no wr_start while busy", pulseCount - p0, 0);
        bus.wr_busy = 1'b0;
        sendBytes(100, 0, 2000, acc);
        check("accepted after busy release", acc, 100);
        waitLen(32'd1024, 3000);
        check("file_length after busy release", bus.file_length, 1024);
        check("busy run fetched mismatches", countMism(c0, 1024, 1024), 0);

        // Sector limit of 3: input refused after 1536 bytes, all three drain
        applyReset();
        loadBpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd1000);
        tick(1);
        p0 = pulseCount; s0 = sectorLog.size();
        sendBytes(2000, 0, 5000, acc);
        check("accepted up to sector limit", acc, 1536);
        check("in_ready at sector limit", 32'(bus.in_ready), 0);
        waitLen(32'd1536, 4000);
        tick(50);
        check("file_length at sector limit", bus.file_length, 1536);
        check("wr_start pulses at sector limit", pulseCount - p0, 3);
        check("third wr_sector", sectorAt(s0 + 2), 2042);
        check("ready held in STOP", 32'(bus.ready), 1);

        // Little-endian multi-byte fields: 0x120 + 1*0x12345 + 1*16 = 0x12475
        applyReset();
        loadBpb(16'd512, 8'h10, 16'h0120, 8'd1, 32'h0001_2345);
        tick(1);
        s0 = sectorLog.size();
        sendBytes(512, 0, 1000, acc);
        waitLen(32'd512, 2000);
        check("start sector from wide fields", sectorAt(s0), 32'h0001_2475);

        // Flush of a 100-byte partial sector
        applyReset();
        loadBpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd1000);
        tick(1);
        p0 = pulseCount; c0 = capt.size();
        sendBytes(100, 0, 200, acc);
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
`ifdef FLUSH_PAD_EN
        check("in_ready while padding", 32'(bus.in_ready), 0);
        waitLen(32'd100, 3000);
        check("file_length after flush", bus.file_length, 100);
        check("wr_start pulses after flush", pulseCount - p0, 1);
        check("padded sector mismatches", countMism(c0, 512, 100), 0);
`else
        check("in_ready after ignored flush", 32'(bus.in_ready), 1);
        tick(600);
        check("no wr_start after ignored flush", pulseCount - p0, 0);
        check("file_length after ignored flush", bus.file_length, 0);
        sendBytes(412, 100, 1000, acc);
        waitLen(32'd512, 2000);
        check("file_length after completing sector", bus.file_length, 512);
        check("unpadded sector mismatches", countMism(c0, 512, 512), 0);
`endif

        // Reset during a transfer: the late wr_done must be ignored
        applyReset();
        loadBpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd1000);
        tick(1);
        sendBytes(512, 0, 1000, acc);
        tick(20);
        check("transfer in flight before reset", 32'(respBusy), 1);
        applyReset();
        p0 = pulseCount;
        loadBpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd1000);
        tick(1);
        waitSinkIdle(2000);
        tick(5);
        check("file_length after stale wr_done", bus.file_length, 0);
        check("no wr_start after mid-transfer reset", pulseCount - p0, 0);
        check("in_ready after mid-transfer reset", 32'(bus.in_ready), 1);

        // Invalid BPB: 4096 bytes/sector
        applyReset();
        loadBpb(16'd4096, 8'd8, 16'd32, 8'd2, 32'd1000);
        tick(1);
        check("err on 4096 bytes/sector", 32'(bus.err), 1);
        check("ready on 4096 bytes/sector", 32'(bus.ready), 0);
        check("in_ready in ERR", 32'(bus.in_ready), 0);
        sendBytes(10, 0, 30, acc);
        check("bytes accepted in ERR", acc, 0);
        tick(5);
        check("err held", 32'(bus.err), 1);

        // Invalid BPB: no FATs, then zero sectors/cluster
        applyReset();
        loadBpb(16'd512, 8'd8, 16'd32, 8'd0, 32'd1000);
        tick(1);
        check("err on nfat=0", 32'(bus.err), 1);
        applyReset();
        loadBpb(16'd512, 8'd0, 16'd32, 8'd2, 32'd1000);
        tick(1);
        check("err on spc=0", 32'(bus.err), 1);
        check("ready on spc=0", 32'(bus.ready), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
